sequence_checker: RTL and testbench
===================================

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, the number of rounds needed to win (legal range 2..31).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins a new game.
REQ-005 SHALL have port rnd, input, 2, random symbol from the game random generator; sampled only in ADD.
REQ-006 SHALL have port show_tick, input, 1, one-cycle pacing pulse for playback.
REQ-007 SHALL have port btn_valid, input, 1, one-cycle pulse marking a player press.
REQ-008 SHALL have port btn_code, input, 2, symbol pressed; qualified by btn_valid.
REQ-009 SHALL have port show_valid, output, 1, one-cycle strobe for a played-back symbol.
REQ-010 SHALL have port show_code, output, 2, played-back symbol; held between strobes.
REQ-011 SHALL have port level, output, 5, current sequence length.
REQ-012 SHALL have port game_state, output, 2, encoded as IDLE=00, RUN=01, OVER=10, WIN=11.
REQ-013 SHALL have port hit, output, 1, one-cycle pulse on a correct press.
REQ-014 SHALL have port miss, output, 1, one-cycle pulse on a wrong press.

Function
REQ-015 SHALL implement an FSM with states IDLE, ADD, SHOW, INPUT, OVER, WIN.
REQ-016 SHALL store the sequence in a MAX_LEN x 2-bit register array, addressed by len (write) and idx (read/compare).
REQ-017 IDLE, OVER, WIN: start SHALL set len=0 and idx=0, and move to ADD on the next edge; all other inputs are ignored.
REQ-018 ADD (exactly one cycle): SHALL write mem[len]<=rnd, len<=len+1, idx<=0, then go to SHOW.
REQ-019 SHOW, show_tick with idx<len: SHALL register show_valid=1 and show_code=mem[idx], and increment idx; show_valid SHALL drop the next cycle unless another tick arrives.
REQ-020 SHOW, show_tick with idx==len: SHALL set idx<=0 and go to INPUT, with no show_valid strobe.
REQ-021 INPUT, btn_valid with btn_code==mem[idx]: SHALL pulse hit.
  - If idx<len-1: idx++.
  - If idx==len-1 and len<MAX_LEN: go to ADD.
  - If idx==len-1 and len==MAX_LEN: go to WIN.
REQ-022 INPUT, btn_valid with btn_code!=mem[idx]: SHALL pulse miss and go to OVER; len is retained so the reached level stays visible.
REQ-023 btn_valid outside INPUT SHALL be ignored, with no hit or miss.
REQ-024 start in ADD, SHOW, or INPUT SHALL be ignored.
REQ-025 game_state SHALL be combinational from the FSM: IDLE->00, ADD/SHOW/INPUT->01, OVER->10, WIN->11.
REQ-026 level SHALL equal len, which saturates at MAX_LEN; idx SHALL never exceed len.
REQ-027 hit, miss, and show_valid SHALL be registered and mutually exclusive in any cycle.
REQ-028 show_tick and btn_valid arriving together SHALL each be honoured only in its own state.

Reset
REQ-029 On rst_n low, at any time including mid-game: state=IDLE, len=0, idx=0, show_valid=0, show_code=00, hit=0, miss=0, game_state=00, level=0.
REQ-030 The sequence memory need not be reset; it SHALL never be read at an index >= len.
REQ-031 The FSM SHALL leave reset only on a clock edge after rst_n rises.

Verification
REQ-032 Reset then start, rnd=10 -> one cycle later level=1, game_state=01; first show_tick gives show_valid=1 with show_code=10; second show_tick enters INPUT.
REQ-033 Round 1 stored 10; press btn_code=10 -> hit pulse, ADD taken, rnd=01 stored, level=2; playback then shows 10, 01 on successive ticks.
REQ-034 Sequence 10,01 in INPUT; press 10 then 11 -> hit, then miss; game_state=10; level stays 2; further presses give no pulses.
REQ-035 MAX_LEN=2; both rounds answered correctly -> game_state=11 after the final hit; start -> level=1, game_state=01.
REQ-036 btn_valid pulses during SHOW and ADD -> no hit or miss, idx unchanged; start during INPUT -> ignored.
REQ-037 rst_n asserted mid-SHOW with show_valid=1 -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sequence_checker.sv
// Memory-game sequence checker: grows a random 2-bit symbol sequence one round
// at a time, plays it back on show_tick, then compares the player's presses.
module sequence_checker #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] rnd,
  input  logic       show_tick,
  input  logic       btn_valid,
  input  logic [1:0] btn_code,
  output logic       show_valid,
  output logic [1:0] show_code,
  output logic [4:0] level,
  output logic [1:0] game_state,
  output logic       hit,
  output logic       miss
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned LW = 5;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD   = 3'd1;
  localparam logic [2:0] S_SHOW  = 3'd2;
  localparam logic [2:0] S_INPUT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;

  logic [2:0]    state, state_d;
  logic [LW-1:0] len, len_d;
  logic [LW-1:0] idx, idx_d;
  logic [1:0]    mem [MAX_LEN];
  logic [1:0]    rd_sym;
  logic          wr_en;
  logic          show_valid_d;
  logic [1:0]    show_code_d;
  logic          hit_d;
  logic          miss_d;

  // idx stays below len whenever rd_sym is consumed, so unwritten slots are never used
  assign rd_sym = mem[idx[AW-1:0]];

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state;
    len_d        = len;
    idx_d        = idx;
    wr_en        = 1'b0;
    show_valid_d = 1'b0;
    show_code_d  = show_code;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    case (state)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        wr_en   = 1'b1;
        len_d   = len + 1'b1;
        idx_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (show_tick) begin
          if (idx < len) begin
            show_valid_d = 1'b1;
            show_code_d  = rd_sym;
            idx_d        = idx + 1'b1;
          end else begin
            idx_d   = '0;
            state_d = S_INPUT;
          end
        end
      end
      S_INPUT: begin
        if (btn_valid) begin
          if (btn_code == rd_sym) begin
            hit_d = 1'b1;
            if (idx == len - 1'b1) begin
              state_d = (len == LEN_MAX) ? S_WIN : S_ADD;
            end else begin
              idx_d = idx + 1'b1;
            end
          end else begin
            miss_d  = 1'b1;
            state_d = S_OVER;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      idx        <= '0;
      show_valid <= 1'b0;
      show_code  <= 2'b00;
      hit        <= 1'b0;
      miss       <= 1'b0;
    end else begin
      state      <= state_d;
      len        <= len_d;
      idx        <= idx_d;
      show_valid <= show_valid_d;
      show_code  <= show_code_d;
      hit        <= hit_d;
      miss       <= miss_d;
    end
  end

  // Sequence storage; no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[len[AW-1:0]] <= rnd;
    end
  end

  assign level = len;

  always_comb begin
    game_state = 2'b00;
    case (state)
      S_ADD, S_SHOW, S_INPUT: game_state = 2'b01;
      S_OVER:                 game_state = 2'b10;
      S_WIN:                  game_state = 2'b11;
      default:                game_state = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: a default-length instance and a
// MAX_LEN=2 instance share stimulus; outputs are compared as packed words.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rnd = 2'b00;
  logic       show_tick = 1'b0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_code = 2'b00;

  logic       sv_a, sv_b, hit_a, hit_b, miss_a, miss_b;
  logic [1:0] sc_a, sc_b, gs_a, gs_b;
  logic [4:0] lvl_a, lvl_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequence_checker dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .rnd(rnd), .show_tick(show_tick),
    .btn_valid(btn_valid), .btn_code(btn_code), .show_valid(sv_a), .show_code(sc_a),
    .level(lvl_a), .game_state(gs_a), .hit(hit_a), .miss(miss_a)
  );

  sequence_checker #(.MAX_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rnd(rnd), .show_tick(show_tick),
    .btn_valid(btn_valid), .btn_code(btn_code), .show_valid(sv_b), .show_code(sc_b),
    .level(lvl_b), .game_state(gs_b), .hit(hit_b), .miss(miss_b)
  );

  // {show_valid, show_code, level, game_state, hit, miss}
  logic [11:0] out_a, out_b;
  assign out_a = {sv_a, sc_a, lvl_a, gs_a, hit_a, miss_a};
  assign out_b = {sv_b, sc_b, lvl_b, gs_b, hit_b, miss_b};

  typedef struct {
    logic       st;
    logic [1:0] rn;
    logic       tk;
    logic       bv;
    logic [1:0] bc;
    logic       sv;
    logic [1:0] sc;
    logic [4:0] lvl;
    logic [1:0] gs;
    logic       h;
    logic       m;
  } vec_t;

  function automatic logic [11:0] pk(logic sv, logic [1:0] sc, logic [4:0] lvl,
                                     logic [1:0] gs, logic h, logic m);
    return {sv, sc, lvl, gs, h, m};
  endfunction

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sv/sc/lvl/gs/hit/miss=%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
               name, act[11], act[10:9], act[8:4], act[3:2], act[1], act[0],
               exp[11], exp[10:9], exp[8:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(logic st, logic [1:0] rn, logic tk, logic bv, logic [1:0] bc);
    @(negedge clk);
    start = st; rnd = rn; show_tick = tk; btn_valid = bv; btn_code = bc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; show_tick = 1'b0; btn_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    // start rnd=10, round 1, ignored inputs, round 2 (10,01), miss, restart
    tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 5'd1, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 5'd1, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 5'd1, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 5'd1, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 5'd1, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 5'd1, 2'b01, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 5'd2, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 5'd2, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 5'd2, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 5'd2, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01, 5'd2, 2'b01, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b01, 5'd2, 2'b10, 1'b0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 5'd2, 2'b10, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 5'd2, 2'b10, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 5'd0, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 5'd1, 2'b01, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 5'd1, 2'b01, 1'b0, 1'b0});

    do_reset();
    @(posedge clk); #1;
    chk("reset_a", out_a, pk(1'b0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b0));
    chk("reset_b", out_b, pk(1'b0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].rn, tbl[i].tk, tbl[i].bv, tbl[i].bc);
      chk($sformatf("vec%0d_a", i), out_a,
          pk(tbl[i].sv, tbl[i].sc, tbl[i].lvl, tbl[i].gs, tbl[i].h, tbl[i].m));
      chk($sformatf("vec%0d_b", i), out_b,
          pk(tbl[i].sv, tbl[i].sc, tbl[i].lvl, tbl[i].gs, tbl[i].h, tbl[i].m));
    end

    // Win on the MAX_LEN=2 instance; the default instance keeps growing
    do_reset();
    step(1'b1, 2'b10, 1'b0, 1'b0, 2'b00);
    step(1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
    step(1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    chk("win_show2", out_b, pk(1'b1, 2'b01, 5'd2, 2'b01, 1'b0, 1'b0));
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
    step(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
    chk("win_final_b", out_b, pk(1'b0, 2'b01, 5'd2, 2'b11, 1'b1, 1'b0));
    chk("win_final_a", out_a, pk(1'b0, 2'b01, 5'd2, 2'b01, 1'b1, 1'b0));
    step(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
    chk("win_hold_b", out_b, pk(1'b0, 2'b01, 5'd2, 2'b11, 1'b0, 1'b0));
    chk("grow_a", out_a, pk(1'b0, 2'b01, 5'd3, 2'b01, 1'b0, 1'b0));
    step(1'b1, 2'b11, 1'b0, 1'b0, 2'b00);
    chk("restart_b", out_b, pk(1'b0, 2'b01, 5'd0, 2'b01, 1'b0, 1'b0));
    chk("start_in_show_a", out_a, pk(1'b0, 2'b01, 5'd3, 2'b01, 1'b0, 1'b0));
    step(1'b0, 2'b11, 1'b0, 1'b0, 2'b00);
    chk("restart_add_b", out_b, pk(1'b0, 2'b01, 5'd1, 2'b01, 1'b0, 1'b0));

    // Asynchronous reset while a show strobe is high
    do_reset();
    step(1'b1, 2'b10, 1'b0, 1'b0, 2'b00);
    step(1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    step(1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
    chk("pre_rst_a", out_a, pk(1'b1, 2'b10, 5'd1, 2'b01, 1'b0, 1'b0));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_a", out_a, pk(1'b0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b0));
    chk("async_rst_b", out_b, pk(1'b0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b0));
    @(negedge clk);
    show_tick = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 2'b00, 1'b1, 1'b1, 2'b10);
    chk("post_rst_a", out_a, pk(1'b0, 2'b00, 5'd0, 2'b00, 1'b0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
